// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: two-entry skid-buffered pipeline stage with a registered in_ready
module pipe_reg_skid #(
  parameter int DATA_W   = 175,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);
  logic              r_main_v, r_skid_v;
  logic [DATA_W-1:0] r_main_d, r_skid_d;
  logic              w_acc, w_rel;
  assign w_acc     = in_valid & ~r_skid_v;
  assign w_rel     = r_main_v & out_ready;
  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;
  assign occ       = {1'b0, r_main_v} + {1'b0, r_skid_v};
  // skid can only be valid while main is valid, so the final branch covers main empty or draining
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (clr) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      if (CLR_DATA) begin
        r_main_d <= '0;
        r_skid_d <= '0;
      end
    end else if (r_main_v & ~w_rel) begin
      if (w_acc) begin
        r_skid_d <= in_data;
        r_skid_v <= 1'b1;
      end
    end else if (r_skid_v) begin
      r_main_d <= r_skid_d;
      r_skid_v <= 1'b0;
    end else begin
      r_main_v <= w_acc;
      if (w_acc) r_main_d <= in_data;
    end
  end
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed and randomized checks of pipe_reg_skid at DATA_W 175 and 8
module tb_pipe_reg_skid;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst, clr, in_valid, out_ready;
  logic [174:0] in_data;
  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [174:0] out_data_a;
  logic [7:0]   out_data_b;
  logic [1:0]   occ_a, occ_b;
  int checks = 0, errors = 0;
  logic [174:0] m_q[$];

  pipe_reg_skid dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .occ(occ_a)
  );
  pipe_reg_skid #(.DATA_W(8), .CLR_DATA(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data[7:0]), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .occ(occ_b)
  );

  // The reference is an ordered queue holding at most two entries.
  task automatic tick(input logic iv, input logic [174:0] id, input logic ordy, input logic c, input logic r);
    bit acc, rel;
    in_valid = iv; in_data = id; out_ready = ordy; clr = c; rst = r;
    acc = iv && m_q.size() < 2;
    rel = m_q.size() > 0 && ordy;
    @(posedge clk);
    if (r || c) m_q.delete();
    else begin
      if (rel) void'(m_q.pop_front());
      if (acc) m_q.push_back(id);
    end
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 175'h9, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({in_ready_a, out_valid_a, occ_a} !== 4'b1000)
      begin errors++; $display("FAIL reset_flags_a: got %b expected 1000", {in_ready_a, out_valid_a, occ_a}); end
    checks++;
    if ({in_ready_b, out_valid_b, occ_b} !== 4'b1000)
      begin errors++; $display("FAIL reset_flags_b: got %b expected 1000", {in_ready_b, out_valid_b, occ_b}); end
    checks++;
    if (out_data_a !== '0 || out_data_b !== '0)
      begin errors++; $display("FAIL reset_data: got %0h/%0h expected 0", out_data_a, out_data_b); end
  endtask

  task automatic test_pass_through();
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 175'(i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== 175'(i) || out_data_b !== 8'(i))
        begin errors++; $display("FAIL pass_data%0d: got %b %0h/%0h expected 1 %0h", i, out_valid_a, out_data_a, out_data_b, i); end
      checks++;
      if (occ_a !== 2'd1 || in_ready_a !== 1'b1)
        begin errors++; $display("FAIL pass_occ%0d: got occ %0d rdy %b expected 1 1", i, occ_a, in_ready_a); end
    end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (occ_a !== 2'd0 || out_valid_a !== 1'b0)
      begin errors++; $display("FAIL pass_drain: got occ %0d vld %b expected 0 0", occ_a, out_valid_a); end
  endtask

  task automatic test_stall_skid();
    tick(1'b1, 175'hA, 1'b0, 1'b0, 1'b0);
    checks++;
    if (occ_a !== 2'd1 || in_ready_a !== 1'b1 || out_data_a !== 175'hA)
      begin errors++; $display("FAIL stall_first: got occ %0d rdy %b data %0h expected 1 1 a", occ_a, in_ready_a, out_data_a); end
    tick(1'b1, 175'hB, 1'b0, 1'b0, 1'b0);
    checks++;
    if (occ_a !== 2'd2 || in_ready_a !== 1'b0 || out_data_a !== 175'hA || in_ready_b !== 1'b0)
      begin errors++; $display("FAIL stall_skid: got occ %0d rdy %b data %0h expected 2 0 a", occ_a, in_ready_a, out_data_a); end
    tick(1'b1, 175'hD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (occ_a !== 2'd2 || out_data_a !== 175'hA || out_data_b !== 8'hA)
      begin errors++; $display("FAIL stall_hold: got occ %0d data %0h/%0h expected 2 a", occ_a, out_data_a, out_data_b); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (occ_a !== 2'd1 || in_ready_a !== 1'b1 || out_data_a !== 175'hB || out_data_b !== 8'hB)
      begin errors++; $display("FAIL stall_release_a: got occ %0d rdy %b data %0h expected 1 1 b", occ_a, in_ready_a, out_data_a); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (occ_a !== 2'd0 || out_valid_a !== 1'b0)
      begin errors++; $display("FAIL stall_release_b: got occ %0d vld %b expected 0 0", occ_a, out_valid_a); end
  endtask

  task automatic test_flush();
    tick(1'b1, 175'hA, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 175'hB, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 175'hC, 1'b0, 1'b1, 1'b0);
    checks++;
    if (occ_a !== 2'd0 || out_valid_a !== 1'b0 || out_data_a !== '0)
      begin errors++; $display("FAIL flush_clear: got occ %0d vld %b data %0h expected 0 0 0", occ_a, out_valid_a, out_data_a); end
    checks++;
    if (occ_b !== 2'd0 || out_valid_b !== 1'b0 || out_data_b !== 8'hA)
      begin errors++; $display("FAIL flush_keep_data: got occ %0d vld %b data %0h expected 0 0 a", occ_b, out_valid_b, out_data_b); end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0)
        begin errors++; $display("FAIL flush_no_c%0d: got vld %b/%b expected 0", i, out_valid_a, out_valid_b); end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 175'hA, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 175'hB, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 175'h7, 1'b1, 1'b0, 1'b1);
    checks++;
    if (occ_a !== 2'd0 || in_ready_a !== 1'b1 || out_data_a !== '0 || out_data_b !== '0)
      begin errors++; $display("FAIL rstmid_clear: got occ %0d rdy %b data %0h/%0h expected 0 1 0", occ_a, in_ready_a, out_data_a, out_data_b); end
    tick(1'b1, 175'h5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 175'h5 || occ_a !== 2'd1)
      begin errors++; $display("FAIL rstmid_first: got vld %b data %0h occ %0d expected 1 5 1", out_valid_a, out_data_a, occ_a); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [191:0] w;
    logic [174:0] head;
    for (int n = 0; n < 10000; n++) begin
      checks++;
      if (occ_a !== 2'(m_q.size()) || occ_b !== 2'(m_q.size()))
        begin errors++; $display("FAIL rand_occ@%0d: got %0d/%0d expected %0d", n, occ_a, occ_b, m_q.size()); end
      checks++;
      if (in_ready_a !== (m_q.size() < 2) || in_ready_b !== (m_q.size() < 2))
        begin errors++; $display("FAIL rand_ready@%0d: got %b/%b expected %b", n, in_ready_a, in_ready_b, m_q.size() < 2); end
      checks++;
      if (out_valid_a !== (m_q.size() > 0) || out_valid_b !== (m_q.size() > 0))
        begin errors++; $display("FAIL rand_valid@%0d: got %b/%b expected %b", n, out_valid_a, out_valid_b, m_q.size() > 0); end
      checks++;
      if (in_ready_a && occ_a == 2'd2)
        begin errors++; $display("FAIL rand_ready_full@%0d: got rdy 1 occ 2 expected rdy 0", n); end
      if (m_q.size() > 0) begin
        head = m_q[0];
        checks++;
        if (out_data_a !== head || out_data_b !== head[7:0])
          begin errors++; $display("FAIL rand_data@%0d: got %0h/%0h expected %0h", n, out_data_a, out_data_b, head); end
      end
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick($urandom_range(0, 9) < 7, w[174:0], $urandom_range(0, 9) < 6,
           $urandom_range(0, 31) == 0, $urandom_range(0, 999) == 0);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_stall_skid();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
